seq_restoring_divider: RTL

Sequential restoring divider, the inverse of the team's 4x4 Wallace-tree multiplier. It takes a 2W-bit dividend and a W-bit divisor and produces a 2W-bit quotient and a W-bit remainder, one quotient bit per clock. It sits beside the multiplier in the arithmetic block set, so a bench can close the loop with quotient*divisor + remainder == dividend. A start/busy/done handshake makes it usable from a simple controller FSM.

---
 rtl/seq_restoring_divider.sv | 137 +++++++++++++
 1 files changed

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor -> 2W-bit quotient and
// W-bit remainder, one quotient bit per clock, with a start/busy/done handshake.
module seq_restoring_divider #(
    parameter int unsigned W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] quotient,
    output logic [W-1:0]   remainder,
    output logic           dbz
);

    localparam int unsigned CntW = $clog2(2 * W);
    localparam logic [CntW-1:0] CntLoad = CntW'(2 * W - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [2*W-1:0]  d_q, d_d;
    logic [W-1:0]    v_q, v_d;
    logic [W:0]      r_q, r_d;
    logic [2*W-1:0]  q_q, q_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [2*W-1:0]  quotient_q, quotient_d;
    logic [W-1:0]    remainder_q, remainder_d;
    logic            dbz_q, dbz_d;

    // One restoring step: trial subtraction of the divisor from the shifted partial remainder.
    logic [W:0]     r_shift;
    logic [W:0]     r_step;
    logic           q_bit;
    logic [2*W-1:0] q_step;

    always_comb begin
        r_shift = {r_q[W-1:0], d_q[2*W-1]};
        q_bit   = (r_shift >= {1'b0, v_q});
        r_step  = q_bit ? (r_shift - {1'b0, v_q}) : r_shift;
        q_step  = {q_q[2*W-2:0], q_bit};
    end

    // Next-state for the FSM, datapath and result registers.
    always_comb begin
        state_d     = state_q;
        d_d         = d_q;
        v_d         = v_q;
        r_d         = r_q;
        q_d         = q_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        // Handshake flags trail the state by one cycle so done lands after the last step.
        busy_d      = (state_q == StRun);
        done_d      = (state_q == StDone);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    d_d   = dividend;
                    v_d   = divisor;
                    r_d   = '0;
                    q_d   = '0;
                    cnt_d = CntLoad;
                    if (divisor == '0) begin
                        state_d     = StDone;
                        quotient_d  = '1;
                        remainder_d = '0;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                d_d   = {d_q[2*W-2:0], 1'b0};
                r_d   = r_step;
                q_d   = q_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d     = StDone;
                    quotient_d  = q_step;
                    remainder_d = r_step[W-1:0];
                    dbz_d       = 1'b0;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            d_q         <= '0;
            v_q         <= '0;
            r_q         <= '0;
            q_q         <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            d_q         <= d_d;
            v_q         <= v_d;
            r_q         <= r_d;
            q_q         <= q_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign dbz       = dbz_q;

endmodule
